ps2_key_event: RTL and testbench
================================

Name: ps2_key_event

Overview:
Next-generation PS/2 keyboard front end. Receives raw PS/2 frames, decodes E0/F0 prefix sequences into complete key events (make/break, extended, typematic repeat), tracks modifier state and a distinct-press counter, and buffers events in a parametrised FIFO with a valid/ready consumer handshake. It sits between the PS/2 pins and downstream consumers such as scan-code-to-ASCII conversion and seven-segment display logic.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of 2, minimum 2
COUNT_W, 12, width of press_count
SYNC_STAGES, 3, synchroniser flops on ps2_clk and ps2_data; minimum 2
TIMEOUT_CYC, 50000, clk cycles without a ps2_clk falling edge before a partial frame is discarded
REPEAT_EN, 0, 1 = typematic repeats enqueued with rpt=1; 0 = repeats dropped

Ports:
clk  in  1  system clock; all logic is on the rising edge
clrn  in  1  reset, asynchronous assert, active-low
ps2_clk  in  1  raw PS/2 clock pin, asynchronous
ps2_data  in  1  raw PS/2 data pin, asynchronous
ev_ready  in  1  consumer accepts the head event
clr_err  in  1  synchronous clear of the sticky flags
ev_valid  out  1  FIFO not empty
ev_data  out  11  head event {rpt, brk, ext, code[7:0]}; first-word fall-through
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
press_count  out  COUNT_W  count of non-repeat make events; wraps modulo 2^COUNT_W
mods  out  4  {caps_lock, ctrl, rshift, lshift}
overflow  out  1  sticky; an event was dropped because the FIFO was full
frame_err  out  1  sticky; a bad frame or timeout was discarded

Behaviour:
- Reset (clrn=0, asynchronous): all outputs are 0, the FIFO is empty, the decoder is IDLE, the held register is cleared, and the bit counter is 0.
- Receiver: ps2_clk and ps2_data pass through SYNC_STAGES flops. A falling edge of the synchronised clock shifts in one bit. Each frame has 11 bits: start=0, data[7:0] LSB first, odd parity, stop=1.
- Frame check: on the 11th edge, if start=0, parity is odd, and stop=1, the receiver emits a 1-cycle byte_valid. Otherwise it drops the byte and sets frame_err.
- Timeout: if the bit counter is nonzero and TIMEOUT_CYC cycles pass with no edge, the counter resets to 0 and frame_err is set.
- Decoder FSM states: IDLE, E0, F0, E0F0.
  - IDLE: byte E0 goes to E0; byte F0 goes to F0; any other byte emits {ext=0, brk=0}.
  - E0: byte F0 goes to E0F0; any other byte emits {ext=1, brk=0}.
  - F0: any byte emits {ext=0, brk=1}.
  - E0F0: any byte emits {ext=1, brk=1}.
  - Every emit returns the FSM to IDLE.
  - An E0 or F0 byte arriving in a non-IDLE state restarts the sequence from that byte.
- Typematic handling:
  - The held register stores {ext, code} of the last make.
  - A make equal to held is a repeat. It is enqueued with rpt=1 only if REPEAT_EN=1, otherwise dropped.
  - A non-repeat make loads held and increments press_count.
  - A break matching held clears held.
  - A break never counts toward press_count.
- Modifiers, updated on emit regardless of FIFO space:
  - lshift (code 12) and rshift (code 59) are set on make and cleared on break.
  - ctrl (code 14, ext 0 or 1) is set on make and cleared on break.
  - caps_lock (code 58) toggles on a non-repeat make only.
- FIFO:
  - Push on emit. Pop when ev_valid and ev_ready are both high.
  - When full, a push is accepted only if a pop occurs in the same cycle. Otherwise the event is dropped and overflow is set.
  - Simultaneous push and pop when not full leaves fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - ev_ready while empty has no effect.
- Latency: with the FIFO empty, ev_valid rises exactly 3 clk cycles after the cycle in which the stop-bit falling edge is detected.
- clr_err clears overflow and frame_err. If a new error occurs in the same cycle, the set wins.
- Reset mid-frame: the partial frame and any pending prefix state are discarded.

Decomposition:
- Package ps2_pkg:
  - scan constants SC_E0=8'hE0, SC_F0=8'hF0, SC_LSHIFT=8'h12, SC_RSHIFT=8'h59, SC_CTRL=8'h14, SC_CAPS=8'h58
  - event field bit positions (RPT=10, BRK=9, EXT=8)
  - decoder state enum
- Sub-module ps2_rx_frame: synchroniser, edge detect, shift register, frame check, and timeout. Outputs byte, byte_valid, and err_pulse.
- Decoder, typematic logic, modifiers, and FIFO live in the top of this block.

Test Plan:
- Send frame 1C alone → ev_data=11'h01C after exactly 3 cycles; press_count=1; fifo_level=1.
- Send E0,F0,75 → single event 11'h375 (brk=1, ext=1).
- REPEAT_EN=0: send 1C,1C,1C,F0,1C → events 11'h01C then 11'h21C; press_count=1.
- Send 12, then 58, then F0,12 → mods=4'b1001 after 58; mods=4'b1000 after the break.
- FIFO_DEPTH=4, ev_ready=0: send 5 makes of distinct keys → fifo_level=4, overflow=1. Then ev_ready=1 → 4 events drain in order.
- Bad parity frame, then a frame truncated for TIMEOUT_CYC+1 cycles → no events, frame_err=1. clr_err clears it. The next good frame decodes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: scan-code constants, event field positions and decoder states shared by the PS/2 key-event block
package ps2_pkg;
    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam int RPT = 10;
    localparam int BRK = 9;
    localparam int EXT = 8;
    typedef enum logic [1:0] {IDLE, E0, F0, E0F0} dec_state_t;
endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: synchronises the PS/2 pins, shifts in 11-bit frames on falling clock edges,
// checks start/parity/stop and discards partial frames after an idle timeout
module ps2_rx_frame #(
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       err_pulse
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [SYNC_STAGES-1:0] ck_s, dt_s;
    logic          ck_d;
    logic [3:0]    bit_cnt;
    logic [9:0]    sr;
    logic [TW-1:0] idle_cnt;
    logic          fall, din, good;
    assign fall = ck_d & ~ck_s[SYNC_STAGES-1];
    assign din  = dt_s[SYNC_STAGES-1];
    // sr holds {parity, data[7:0], start}; the stop bit is the live input
    assign good = ~sr[0] & din & (^sr[9:1]);
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ck_s       <= '1;
            dt_s       <= '1;
            ck_d       <= 1'b1;
            bit_cnt    <= '0;
            sr         <= '0;
            idle_cnt   <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            ck_s       <= {ck_s[SYNC_STAGES-2:0], ps2_clk};
            dt_s       <= {dt_s[SYNC_STAGES-2:0], ps2_data};
            ck_d       <= ck_s[SYNC_STAGES-1];
            byte_valid <= 1'b0;
            err_pulse  <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt    <= '0;
                    rx_byte    <= good ? sr[8:1] : rx_byte;
                    byte_valid <= good;
                    err_pulse  <= ~good;
                end else begin
                    sr      <= {din, sr[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    bit_cnt   <= '0;
                    idle_cnt  <= '0;
                    err_pulse <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + TW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/ps2_key_event.sv
// ps2_key_event: PS/2 keyboard front end decoding prefix sequences into key events,
// tracking modifiers/typematic state and buffering events in a first-word fall-through FIFO
module ps2_key_event import ps2_pkg::*; #(
    parameter int FIFO_DEPTH  = 8,
    parameter int COUNT_W     = 12,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 50000,
    parameter int REPEAT_EN   = 0
) (
    input  logic                        clk,
    input  logic                        clrn,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    input  logic                        ev_ready,
    input  logic                        clr_err,
    output logic                        ev_valid,
    output logic [10:0]                 ev_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [COUNT_W-1:0]          press_count,
    output logic [3:0]                  mods,
    output logic                        overflow,
    output logic                        frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [7:0]    rx_byte;
    logic          byte_valid, rx_err;
    dec_state_t    state;
    logic          push;
    logic [10:0]   push_word;
    logic [8:0]    held, key;
    logic          held_v, is_e0, is_f0, ext_c, brk_c, emit, rep;
    logic [10:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          pop, full, wr;

    ps2_rx_frame #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rx_byte(rx_byte), .byte_valid(byte_valid), .err_pulse(rx_err)
    );

    assign is_e0 = rx_byte == SC_E0;
    assign is_f0 = rx_byte == SC_F0;
    assign ext_c = state == E0 || state == E0F0;
    assign brk_c = state == F0 || state == E0F0;
    assign key   = {ext_c, rx_byte};
    assign emit  = byte_valid & ~is_e0 & ~is_f0;
    assign rep   = ~brk_c & held_v & (held == key);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= IDLE;
            push        <= 1'b0;
            push_word   <= '0;
            held        <= '0;
            held_v      <= 1'b0;
            press_count <= '0;
            mods        <= '0;
        end else begin
            push <= 1'b0;
            if (byte_valid)
                state <= is_e0 ? E0 : is_f0 ? (state == E0 ? E0F0 : F0) : IDLE;
            if (emit) begin
                push           <= ~rep | (REPEAT_EN != 0);
                push_word[RPT] <= rep;
                push_word[BRK] <= brk_c;
                push_word[EXT:0] <= key;
                if (~brk_c & ~rep) begin
                    held        <= key;
                    held_v      <= 1'b1;
                    press_count <= press_count + COUNT_W'(1);
                end
                if (brk_c & held_v & (held == key)) begin
                    held   <= '0;
                    held_v <= 1'b0;
                end
                if (key == {1'b0, SC_LSHIFT}) mods[0] <= ~brk_c;
                if (key == {1'b0, SC_RSHIFT}) mods[1] <= ~brk_c;
                if (rx_byte == SC_CTRL)       mods[2] <= ~brk_c;
                if (key == {1'b0, SC_CAPS} && ~brk_c && ~rep) mods[3] <= ~mods[3];
            end
        end
    end

    assign ev_valid = fifo_level != '0;
    assign pop      = ev_valid & ev_ready;
    assign full     = fifo_level == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH);
    // a full FIFO still takes a push when the head leaves in the same cycle
    assign wr       = push & (~full | pop);
    assign ev_data  = ev_valid ? mem[rptr] : '0;

    always_ff @(posedge clk)
        if (wr) mem[wptr] <= push_word;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (wr)  wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            if (wr & ~pop) fifo_level <= fifo_level + 1'b1;
            if (pop & ~wr) fifo_level <= fifo_level - 1'b1;
            overflow  <= (push & ~wr) ? 1'b1 : clr_err ? 1'b0 : overflow;
            frame_err <= rx_err ? 1'b1 : clr_err ? 1'b0 : frame_err;
        end
    end
endmodule

// File: tb/tb_ps2_key_event.sv
// tb_ps2_key_event: scoreboard bench driving PS/2 frames and checking events, counters, modifiers and flags
module tb_ps2_key_event;
    localparam int FD = 4;
    localparam int TO = 200;
    localparam int SS = 3;
    logic        clk = 0, clrn = 0, ps2_clk = 1, ps2_data = 1, ev_ready = 1, clr_err = 0;
    logic        ev_valid, overflow, frame_err;
    logic [10:0] ev_data;
    logic [2:0]  fifo_level;
    logic [11:0] press_count;
    logic [3:0]  mods;
    int          vectors = 0, miscompares = 0;
    logic [10:0] exp_q [$];

    always #5 clk = ~clk;

    ps2_key_event #(.FIFO_DEPTH(FD), .COUNT_W(12), .SYNC_STAGES(SS), .TIMEOUT_CYC(TO), .REPEAT_EN(0)) dut (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ev_ready(ev_ready),
        .clr_err(clr_err), .ev_valid(ev_valid), .ev_data(ev_data), .fifo_level(fifo_level),
        .press_count(press_count), .mods(mods), .overflow(overflow), .frame_err(frame_err)
    );

    always @(negedge clk) begin
        if (clrn && ev_valid && ev_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL event_unexpected: got %h want none", ev_data);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                if (ev_data !== e) begin
                    miscompares++;
                    $display("FAIL event_data: got %h want %h", ev_data, e);
                end
            end
        end
    end

    function automatic logic [10:0] mk(input logic [7:0] b, input logic bad);
        return {1'b1, ~(^b) ^ bad, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = fr[i];
            repeat (4) @(posedge clk);
            #1 ps2_clk = 0;
            repeat (4) @(posedge clk);
            #1 ps2_clk = 1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(mk(b, 1'b0), 11);
        repeat (4) @(posedge clk);
    endtask

    task automatic settle;
        repeat (10) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        #1 clrn = 0;
        ps2_clk = 1; ps2_data = 1; ev_ready = 1; clr_err = 0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 clrn = 1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset;
        #1 clrn = 0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({ev_valid, ev_data, fifo_level, press_count, mods, overflow, frame_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b d=%h l=%0d pc=%0d m=%b o=%b fe=%b want all 0",
                     ev_valid, ev_data, fifo_level, press_count, mods, overflow, frame_err);
        end
        do_reset();
        send(8'hF0);
        send_bits(mk(8'h33, 1'b0), 5);
        do_reset();
        exp_q.push_back(11'h01C);
        send(8'h1C);
        settle();
        vectors++;
        if (press_count !== 12'd1 || frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_midframe: got pc=%0d fe=%b want pc=1 fe=0", press_count, frame_err);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_midframe_events: got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic test_single;
        logic [10:0] fr;
        int lat;
        do_reset();
        exp_q.push_back(11'h01C);
        fr = mk(8'h1C, 1'b0);
        send_bits(fr, 10);
        ps2_data = fr[10];
        repeat (4) @(posedge clk);
        #1 ps2_clk = 0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ev_valid) begin
                lat = k;
                break;
            end
        end
        vectors++;
        if (lat !== SS + 3) begin
            miscompares++;
            $display("FAIL latency: got %0d want %0d", lat, SS + 3);
        end
        vectors++;
        if (fifo_level !== 3'd1) begin
            miscompares++;
            $display("FAIL level_single: got %0d want 1", fifo_level);
        end
        repeat (3) @(posedge clk);
        #1 ps2_clk = 1;
        settle();
        vectors++;
        if (press_count !== 12'd1) begin
            miscompares++;
            $display("FAIL count_single: got %0d want 1", press_count);
        end
    endtask

    task automatic test_ext_break;
        do_reset();
        exp_q.push_back(11'h375);
        send(8'hE0); send(8'hF0); send(8'h75);
        settle();
        vectors++;
        if (exp_q.size() != 0 || press_count !== 12'd0) begin
            miscompares++;
            $display("FAIL ext_break: got pending=%0d pc=%0d want 0 0", exp_q.size(), press_count);
        end
    endtask

    task automatic test_typematic;
        do_reset();
        exp_q.push_back(11'h01C);
        exp_q.push_back(11'h21C);
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        settle();
        vectors++;
        if (press_count !== 12'd1) begin
            miscompares++;
            $display("FAIL typematic_count: got %0d want 1", press_count);
        end
        exp_q.push_back(11'h01C);
        send(8'h1C);
        settle();
        vectors++;
        if (press_count !== 12'd2 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL typematic_remake: got pc=%0d pending=%0d want 2 0", press_count, exp_q.size());
        end
    endtask

    task automatic test_mods;
        do_reset();
        exp_q.push_back(11'h012);
        exp_q.push_back(11'h058);
        send(8'h12);
        settle();
        vectors++;
        if (mods !== 4'b0001) begin
            miscompares++;
            $display("FAIL mods_lshift: got %b want 0001", mods);
        end
        send(8'h58);
        settle();
        vectors++;
        if (mods !== 4'b1001) begin
            miscompares++;
            $display("FAIL mods_caps: got %b want 1001", mods);
        end
        exp_q.push_back(11'h212);
        send(8'hF0); send(8'h12);
        settle();
        vectors++;
        if (mods !== 4'b1000 || press_count !== 12'd2) begin
            miscompares++;
            $display("FAIL mods_break: got m=%b pc=%0d want 1000 2", mods, press_count);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] keys [5];
        keys = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        do_reset();
        ev_ready = 0;
        for (int i = 0; i < 5; i++) begin
            if (i < FD) exp_q.push_back({3'b000, keys[i]});
            send(keys[i]);
        end
        settle();
        vectors++;
        if (fifo_level !== 3'(FD) || overflow !== 1'b1 || ev_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_full: got l=%0d o=%b v=%b want 4 1 1", fifo_level, overflow, ev_valid);
        end
        vectors++;
        if (press_count !== 12'd5) begin
            miscompares++;
            $display("FAIL overflow_count: got %0d want 5", press_count);
        end
        @(posedge clk);
        #1 ev_ready = 1;
        settle();
        vectors++;
        if (fifo_level !== 3'd0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL overflow_drain: got l=%0d pending=%0d want 0 0", fifo_level, exp_q.size());
        end
        @(posedge clk);
        #1 clr_err = 1;
        @(posedge clk);
        #1 clr_err = 0;
        @(negedge clk);
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_clear: got %b want 0", overflow);
        end
    endtask

    task automatic test_errors;
        do_reset();
        send_bits(mk(8'h1C, 1'b1), 11);
        settle();
        vectors++;
        if (frame_err !== 1'b1 || fifo_level !== 3'd0 || press_count !== 12'd0) begin
            miscompares++;
            $display("FAIL parity_err: got fe=%b l=%0d pc=%0d want 1 0 0", frame_err, fifo_level, press_count);
        end
        @(posedge clk);
        #1 clr_err = 1;
        @(posedge clk);
        #1 clr_err = 0;
        @(negedge clk);
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_err: got %b want 0", frame_err);
        end
        send_bits(mk(8'h2B, 1'b0), 4);
        repeat (TO - 30) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early: got %b want 0", frame_err);
        end
        repeat (60) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (frame_err !== 1'b1 || fifo_level !== 3'd0) begin
            miscompares++;
            $display("FAIL timeout_err: got fe=%b l=%0d want 1 0", frame_err, fifo_level);
        end
        @(posedge clk);
        #1 clr_err = 1;
        @(posedge clk);
        #1 clr_err = 0;
        exp_q.push_back(11'h02B);
        send(8'h2B);
        settle();
        vectors++;
        if (frame_err !== 1'b0 || exp_q.size() != 0 || press_count !== 12'd1) begin
            miscompares++;
            $display("FAIL after_err: got fe=%b pending=%0d pc=%0d want 0 0 1", frame_err, exp_q.size(), press_count);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_ext_break();
        test_typematic();
        test_mods();
        test_overflow();
        test_errors();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
